// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the PS/2 set-2 scancode byte stream into per-key held/press/release
//   signals for eight game keys. Tracks F0 (break) and E0 (extended) prefixes,
//   suppresses typematic repeats, flushes held keys on keyboard self-test (AA)
//   and abandons a stale prefix after TIMEOUT_CYCLES idle cycles.
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   keycode      receiver word {previous byte, current byte}; only [7:0] used
//   oflag        one-cycle strobe, keycode[7:0] valid this cycle
//   key_held     level per key: 0 left, 1 right, 2 up, 3 down,
//                4 space, 5 enter, 6 esc, 7 P
//   key_press    one-cycle pulse on a genuine make
//   key_release  one-cycle pulse on a break of a held key
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        oflag,
  output logic [7:0]  key_held,
  output logic [7:0]  key_press,
  output logic [7:0]  key_release
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_held;
  logic [7:0]    r_press;
  logic [7:0]    r_release;

  logic [7:0] w_byte;
  logic       w_ext;
  logic       w_brk;
  logic [7:0] w_mask;
  logic       w_unused;

  assign w_byte   = keycode[7:0];
  assign w_unused = ^keycode[15:8];

  assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

  // Extended flag is part of the match, so keypad codes sharing the low
  // byte with the arrow keys (and E0-prefixed 29 etc.) stay unmapped.
  always_comb begin
    w_mask = '0;
    case ({w_ext, w_byte})
      {1'b1, 8'h6B}: w_mask = 8'h01;
      {1'b1, 8'h74}: w_mask = 8'h02;
      {1'b1, 8'h75}: w_mask = 8'h04;
      {1'b1, 8'h72}: w_mask = 8'h08;
      {1'b0, 8'h29}: w_mask = 8'h10;
      {1'b0, 8'h5A}: w_mask = 8'h20;
      {1'b0, 8'h76}: w_mask = 8'h40;
      {1'b0, 8'h4D}: w_mask = 8'h80;
      default:       w_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      if (oflag) begin
        // A byte always beats a timeout firing in the same cycle.
        r_cnt <= '0;
        case (w_byte)
          8'hF0: begin
            if (r_state == S_IDLE)     r_state <= S_BRK;
            else if (r_state == S_EXT) r_state <= S_EXT_BRK;
          end
          8'hE0: begin
            if (r_state == S_IDLE)     r_state <= S_EXT;
            else if (r_state == S_BRK) r_state <= S_EXT_BRK;
          end
          default: begin
            r_state <= S_IDLE;
            if ((r_state == S_IDLE) && (w_byte == 8'hAA)) begin
              // Hot-plug: every key still down is reported as released.
              r_held    <= '0;
              r_release <= r_held;
            end else if (w_brk) begin
              if ((r_held & w_mask) != '0) begin
                r_held    <= r_held & ~w_mask;
                r_release <= w_mask;
              end
            end else if ((w_mask != '0) && ((r_held & w_mask) == '0)) begin
              r_held  <= r_held | w_mask;
              r_press <= w_mask;
            end
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_cnt == TO_LIMIT) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  logic        clk;
  logic        rst;
  logic [15:0] keycode;
  logic        oflag;
  logic [7:0]  key_held;
  logic [7:0]  key_press;
  logic [7:0]  key_release;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_up_press;

  ps2_key_decoder #(.TIMEOUT_CYCLES(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .keycode     (keycode),
    .oflag       (oflag),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns on the negedge after the
  // processing edge, so the byte's effect is visible on return.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    keycode = {8'($urandom), b};
    oflag   = 1'b1;
    @(negedge clk);
    oflag   = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    n_up_press = 0;
    rst        = 1'b1;
    oflag      = 1'b0;
    keycode    = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_held", key_held, 8'h00);
    chk("rst_press", key_press, 8'h00);
    chk("rst_release", key_release, 8'h00);

    // Make/break of space
    send(8'h29);
    chk("space_press", key_press, 8'h10);
    chk("space_held", key_held, 8'h10);
    idle(1);
    chk("space_press_1cyc", key_press, 8'h00);
    send(8'hF0);
    chk("space_held_f0", key_held, 8'h10);
    chk("space_norel_f0", key_release, 8'h00);
    send(8'h29);
    chk("space_release", key_release, 8'h10);
    chk("space_held_clr", key_held, 8'h00);
    idle(1);
    chk("space_release_1cyc", key_release, 8'h00);

    // Extended vs plain
    send(8'hE0); send(8'h6B);
    chk("left_press", key_press, 8'h01);
    chk("left_held", key_held, 8'h01);
    send(8'h6B);
    chk("kp4_press", key_press, 8'h00);
    chk("kp4_held", key_held, 8'h01);
    send(8'hF0); send(8'h6B);
    chk("kp4_brk_rel", key_release, 8'h00);
    chk("kp4_brk_held", key_held, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("left_release", key_release, 8'h01);
    chk("left_held_clr", key_held, 8'h00);
    send(8'hE0); send(8'h29);
    chk("e0_29_unmapped", key_press, 8'h00);
    send(8'hFA);
    chk("fa_unmapped", key_held, 8'h00);

    // Typematic repeat of up
    for (int unsigned i = 0; i < 5; i++) begin
      send(8'hE0); send(8'h75);
      if (key_press[2]) n_up_press++;
      chk("up_held_rep", key_held, 8'h04);
    end
    chk("up_one_press", 8'(n_up_press), 8'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_release", key_release, 8'h04);

    // Prefix timeout: 60 idle cycles discards E0, 40 does not
    send(8'hE0);
    idle(60);
    send(8'h6B);
    chk("timeout_press", key_press, 8'h00);
    chk("timeout_held", key_held, 8'h00);
    send(8'hE0);
    idle(40);
    send(8'h6B);
    chk("no_timeout_press", key_press, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("no_timeout_rel", key_release, 8'h01);

    // Hot-plug flush
    send(8'h29); send(8'h5A); send(8'hE0); send(8'h74);
    chk("hp_held", key_held, 8'h32);
    send(8'hAA);
    chk("hp_release", key_release, 8'h32);
    chk("hp_held_clr", key_held, 8'h00);
    idle(1);
    chk("hp_release_1cyc", key_release, 8'h00);

    // Reset mid-sequence; byte strobed with rst is dropped
    send(8'hE0); send(8'hF0);
    @(negedge clk);
    rst = 1'b1; oflag = 1'b1; keycode = 16'h0029;
    @(negedge clk);
    rst = 1'b0; oflag = 1'b0;
    chk("rst_drop_held", key_held, 8'h00);
    chk("rst_drop_press", key_press, 8'h00);
    send(8'h6B);
    chk("rst_6b_press", key_press, 8'h00);
    chk("rst_6b_rel", key_release, 8'h00);
    send(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h6B);
    chk("rst_ext_cleared", key_press, 8'h00);

    // Back-to-back strobes
    @(negedge clk);
    oflag = 1'b1; keycode = 16'h00E0;
    @(negedge clk);
    keycode = 16'h0072;
    @(negedge clk);
    keycode = 16'h004D;
    chk("b2b_down_press", key_press, 8'h08);
    @(negedge clk);
    oflag = 1'b0;
    chk("b2b_p_press", key_press, 8'h80);
    chk("b2b_held", key_held, 8'h88);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
